// File: rtl/bc_control_sequencer.sv
// Timing and control unit of the BC_I basic computer: sequence counter plus
// decode of IR and status flags into register strobes, bus select and ALU op.
module bc_control_sequencer #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH+3:0] ir,
    input  logic                  dr_zero,
    input  logic                  ac_zero,
    input  logic                  ac_sign,
    output logic [2:0]            sc,
    output logic [2:0]            bus_sel,
    output logic                  ar_we,
    output logic                  ar_inc,
    output logic                  pc_we,
    output logic                  pc_inc,
    output logic                  dr_we,
    output logic                  dr_inc,
    output logic                  ir_we,
    output logic                  ac_we,
    output logic                  ac_inc,
    output logic                  ac_rst,
    output logic [1:0]            alu_op,
    output logic                  mem_we,
    output logic                  halted
);

    localparam int unsigned I_BIT = ADDR_WIDTH + 3;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [1:0] ALU_CMA  = 2'd3;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int unsigned B_CLA = 11;
    localparam int unsigned B_CMA = 9;
    localparam int unsigned B_INC = 5;
    localparam int unsigned B_SPA = 4;
    localparam int unsigned B_SNA = 3;
    localparam int unsigned B_SZA = 2;
    localparam int unsigned B_HLT = 0;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4,
        T5 = 3'd5,
        T6 = 3'd6
    } t_state_e;

    t_state_e sc_q, sc_d;
    logic     i_ff_q, i_ff_d;
    logic     halted_q, halted_d;

    logic [2:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = ir[ADDR_WIDTH+2:ADDR_WIDTH];
    assign unused_ir_bits = ^{ir[10], ir[8:6], ir[1]};

    // State registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sc_q     <= T0;
            i_ff_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            sc_q     <= sc_d;
            i_ff_q   <= i_ff_d;
            halted_q <= halted_d;
        end
    end

    // Next state and control decode
    always_comb begin
        sc_d     = t_state_e'(3'(sc_q + 3'd1));
        i_ff_d   = i_ff_q;
        halted_d = halted_q;
        bus_sel  = BUS_NONE;
        ar_we    = 1'b0;
        ar_inc   = 1'b0;
        pc_we    = 1'b0;
        pc_inc   = 1'b0;
        dr_we    = 1'b0;
        dr_inc   = 1'b0;
        ir_we    = 1'b0;
        ac_we    = 1'b0;
        ac_inc   = 1'b0;
        ac_rst   = 1'b0;
        alu_op   = 2'd0;
        mem_we   = 1'b0;

        if (halted_q) begin
            sc_d = T0;
            if (start) begin
                halted_d = 1'b0;
            end
        end else begin
            unique case (sc_q)
                T0: begin
                    bus_sel = BUS_PC;
                    ar_we   = 1'b1;
                end
                T1: begin
                    bus_sel = BUS_MEM;
                    ir_we   = 1'b1;
                    pc_inc  = 1'b1;
                end
                T2: begin
                    bus_sel = BUS_IR;
                    ar_we   = 1'b1;
                    i_ff_d  = ir[I_BIT];
                end
                T3: begin
                    if (opcode == OP_REG) begin
                        sc_d = T0;
                        if (!i_ff_q) begin
                            ac_rst = ir[B_CLA];
                            if (ir[B_CMA]) begin
                                ac_we  = 1'b1;
                                alu_op = ALU_CMA;
                            end
                            // CMA owns the AC load port, so INC yields to it
                            ac_inc = ir[B_INC] & ~ir[B_CMA];
                            pc_inc = (ir[B_SPA] & ~ac_sign) |
                                     (ir[B_SNA] &  ac_sign) |
                                     (ir[B_SZA] &  ac_zero);
                            if (ir[B_HLT]) begin
                                halted_d = 1'b1;
                            end
                        end
                    end else if (i_ff_q) begin
                        bus_sel = BUS_MEM;
                        ar_we   = 1'b1;
                    end
                end
                T4: begin
                    unique case (opcode)
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            bus_sel = BUS_MEM;
                            dr_we   = 1'b1;
                        end
                        OP_STA: begin
                            bus_sel = BUS_AC;
                            mem_we  = 1'b1;
                            sc_d    = T0;
                        end
                        OP_BUN: begin
                            bus_sel = BUS_AR;
                            pc_we   = 1'b1;
                            sc_d    = T0;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_PC;
                            mem_we  = 1'b1;
                            ar_inc  = 1'b1;
                        end
                        default: sc_d = T0;
                    endcase
                end
                T5: begin
                    unique case (opcode)
                        OP_AND, OP_ADD, OP_LDA: begin
                            ac_we  = 1'b1;
                            alu_op = opcode[1:0];
                            sc_d   = T0;
                        end
                        OP_BSA: begin
                            bus_sel = BUS_AR;
                            pc_we   = 1'b1;
                            sc_d    = T0;
                        end
                        OP_ISZ: dr_inc = 1'b1;
                        default: sc_d = T0;
                    endcase
                end
                T6: begin
                    sc_d = T0;
                    if (opcode == OP_ISZ) begin
                        bus_sel = BUS_DR;
                        mem_we  = 1'b1;
                        pc_inc  = dr_zero;
                    end
                end
                default: sc_d = T0;
            endcase
        end

        // Reset kills every strobe immediately, without waiting for an edge
        if (RST) begin
            bus_sel = BUS_NONE;
            ar_we   = 1'b0;
            ar_inc  = 1'b0;
            pc_we   = 1'b0;
            pc_inc  = 1'b0;
            dr_we   = 1'b0;
            dr_inc  = 1'b0;
            ir_we   = 1'b0;
            ac_we   = 1'b0;
            ac_inc  = 1'b0;
            ac_rst  = 1'b0;
            alu_op  = 2'd0;
            mem_we  = 1'b0;
        end
    end

    assign sc     = sc_q;
    assign halted = halted_q;

endmodule

// File: doc/bc_control_sequencer.md
Name: bc_control_sequencer

Overview:
- Timing/control unit of the BC_I basic computer; sits directly upstream of the load/reset/increment registers (AR, PC, DR, IR, AC).
- Runs a 3-bit sequence counter (T0..T6) through fetch, decode, indirect and execute phases.
- Decodes IR and status flags into the per-register WE/INC/RST strobes, common-bus select, ALU op and memory write.
- Memory-reference instructions plus a register-reference subset; HLT parks the machine until `start`.

Parameters:
- ADDR_WIDTH, 12, address field width of IR; opcode is IR[ADDR_WIDTH+2:ADDR_WIDTH], indirect bit is IR[ADDR_WIDTH+3].

Ports:
- clk  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- start  input  1  clears halt; sampled on clk.
- ir  input  ADDR_WIDTH+4  current IR register output.
- dr_zero  input  1  DR output == 0.
- ac_zero  input  1  AC output == 0.
- ac_sign  input  1  AC MSB.
- sc  output  3  sequence counter value (T index).
- bus_sel  output  3  common-bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
- ar_we, ar_inc, pc_we, pc_inc, dr_we, dr_inc, ir_we, ac_we, ac_inc, ac_rst  output  1 each  register strobes.
- alu_op  output  2  0 AND, 1 ADD, 2 pass DR, 3 complement AC; meaningful only with ac_we.
- mem_we  output  1  write bus value to M[AR].
- halted  output  1  halt flip-flop.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high (RST).
- State: sc, i_ff, halted.
  - On RST: all three go to 0 immediately.
  - While RST is high, every control output is forced to 0.
- Controls are combinational decodes of sc, i_ff, ir and the flags. Downstream registers act on the next rising edge.
- sc advances by 1 each cycle. "SC<-0" means sc loads 0 at the next edge. sc never exceeds 6.
- Fetch:
  - T0: bus_sel=2, ar_we.
  - T1: bus_sel=7, ir_we, pc_inc.
  - T2: bus_sel=5, ar_we; i_ff <= IR MSB.
- Register-reference, opcode 7 with I=0, all at T3, then SC<-0. Multiple set bits act together.
  - B11 CLA: ac_rst.
  - B9 CMA: ac_we, alu_op=3.
  - B5 INC: ac_inc.
  - B4 SPA: pc_inc if !ac_sign.
  - B3 SNA: pc_inc if ac_sign.
  - B2 SZA: pc_inc if ac_zero.
  - B0 HLT: halted<=1.
  - Other bits are no-ops.
- Opcode 7 with I=1 (I/O) is a no-op: SC<-0 at T3.
- Memory-reference, opcodes 0..6:
  - T3: if i_ff then bus_sel=7, ar_we; otherwise no controls.
  - AND/ADD/LDA (0/1/2): T4 bus_sel=7, dr_we; T5 ac_we with alu_op 0/1/2, SC<-0.
  - STA (3): T4 bus_sel=4, mem_we, SC<-0.
  - BUN (4): T4 bus_sel=1, pc_we, SC<-0.
  - BSA (5): T4 bus_sel=2, mem_we, ar_inc; T5 bus_sel=1, pc_we, SC<-0.
  - ISZ (6): T4 bus_sel=7, dr_we; T5 dr_inc; T6 bus_sel=3, mem_we, pc_inc if dr_zero, SC<-0.
- Halt:
  - While halted=1: sc held at 0, all controls 0, i_ff held.
  - start=1 while halted: halted<=0 at that edge; next cycle is T0 fetch.
  - start while not halted is ignored.
  - HLT plus other bits in the same IR: the other bits still execute at T3.
- At most one of {xx_we, xx_inc} is active per register in any cycle.
- Only one bus_sel source per cycle.

Test Plan:
1. Release RST, ir=16'h1123 (ADD direct) -> T0 bus_sel=2 ar_we; T1 bus_sel=7 ir_we pc_inc; T2 bus_sel=5 ar_we; T3 all 0; T4 bus_sel=7 dr_we; T5 ac_we alu_op=1; sc reads 0 at the following cycle.
2. ir=16'hA050 (LDA indirect) -> T3 bus_sel=7 ar_we; T4 dr_we; T5 ac_we alu_op=2; 6-cycle instruction.
3. ir=16'h6010 (ISZ) -> T5 dr_inc; T6 bus_sel=3 mem_we. With dr_zero=1, pc_inc=1; repeat with dr_zero=0 -> pc_inc=0.
4. ir=16'h7004 (SZA): ac_zero=1 -> pc_inc at T3, sc=0 next. ir=16'h7810 (CLA+SPA) with ac_sign=0 -> ac_rst and pc_inc both at T3.
5. ir=16'h7001 (HLT) -> halted=1 after T3; sc=0 and all controls 0 for 10 cycles; pulse start -> halted=0, next cycle T0 with bus_sel=2.
6. ir=16'h5020 (BSA), assert RST asynchronously mid-T4 -> mem_we/ar_inc drop to 0 without a clock edge; sc=0, halted=0; first post-release cycle is T0.
